// File: rtl/seg_display_driver.sv
// Binary-to-BCD converter (serial double-dabble, 4 digits) with a multiplexed
// active-low 7-segment display driver; values above 9999 display as dashes.
module seg_display_driver #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic [3:0]  tho,
    output logic [3:0]  hun,
    output logic [3:0]  ten,
    output logic [3:0]  one,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [15:0] LP_DIV_LAST = 16'(REFRESH_DIV - 1);

    state_t      r_state;
    logic [13:0] r_sr;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf_pend;
    logic        r_busy;
    logic        r_done;
    logic        r_ovf;
    logic [3:0]  r_tho, r_hun, r_ten, r_one;
    logic [15:0] r_refresh;
    logic [1:0]  r_sel;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;

    logic [14:0] w_adj;
    logic [3:0]  w_digit;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            4'hF:    f_seg = 7'b0111111;
            default: f_seg = 7'b1111111;
        endcase
    endfunction

    // The thousands nibble is at most 4 before the last shift (input <= 9999),
    // so only the lower three nibbles ever need the +3 correction.
    always_comb begin
        w_adj = r_bcd[14:0];
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            r_tho      <= '0;
            r_hun      <= '0;
            r_ten      <= '0;
            r_one      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_busy <= 1'b1;
                        if (value > 32'd9999) begin
                            r_ovf_pend <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_ovf_pend <= 1'b0;
                            r_sr       <= value[13:0];
                            r_bcd      <= '0;
                            r_cnt      <= '0;
                            r_state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_adj, r_sr[13]};
                    r_sr  <= {r_sr[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (r_ovf_pend) begin
                        r_tho <= 4'hF;
                        r_hun <= 4'hF;
                        r_ten <= 4'hF;
                        r_one <= 4'hF;
                        r_ovf <= 1'b1;
                    end else begin
                        r_tho <= r_bcd[15:12];
                        r_hun <= r_bcd[11:8];
                        r_ten <= r_bcd[7:4];
                        r_one <= r_bcd[3:0];
                        r_ovf <= 1'b0;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (r_sel)
            2'd0:    w_digit = r_one;
            2'd1:    w_digit = r_ten;
            2'd2:    w_digit = r_hun;
            default: w_digit = r_tho;
        endcase
    end

    // an and seg are both registered from the same select so they change together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_sel     <= '0;
            r_an      <= 4'b1110;
            r_seg     <= 7'b1000000;
        end else begin
            if (r_refresh == LP_DIV_LAST) begin
                r_refresh <= '0;
                r_sel     <= r_sel + 2'd1;
            end else begin
                r_refresh <= r_refresh + 16'd1;
            end
            r_an  <= ~(4'b0001 << r_sel);
            r_seg <= f_seg(w_digit);
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign tho  = r_tho;
    assign hun  = r_hun;
    assign ten  = r_ten;
    assign one  = r_one;
    assign seg  = r_seg;
    assign an   = r_an;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: conversion latency, overflow,
// load-while-busy, display refresh sequencing and reset behaviour.
module tb_seg_display_driver;

    logic        clk;
    logic        reset;
    logic        load;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  tho, hun, ten, one;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    seg_display_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .tho   (tho),
        .hun   (hun),
        .ten   (ten),
        .one   (one),
        .seg   (seg),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'b1110) begin
            n_errors++; $display("FAIL reset_an got %b want 1110", an);
        end
        n_checks++;
        if (seg !== 7'b1000000) begin
            n_errors++; $display("FAIL reset_seg got %b want 1000000", seg);
        end
        n_checks++;
        if ({tho, hun, ten, one} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state got digits %h busy %b done %b ovf %b want 0000 0 0 0",
                     {tho, hun, ten, one}, busy, done, ovf);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_normal();
        int bad_busy;
        bad_busy = 0;
        @(negedge clk);
        value = 32'd1234; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i <= 14; i++) begin
            if (i > 0) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
        end
        n_checks++;
        if (bad_busy != 0) begin
            n_errors++; $display("FAIL normal_busy got %0d bad cycles want 0", bad_busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_errors++; $display("FAIL normal_done got done %b busy %b want 1 0", done, busy);
        end
        n_checks++;
        if ({tho, hun, ten, one} !== 16'h1234 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL normal_digits got %h ovf %b want 1234 0", {tho, hun, ten, one}, ovf);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_errors++; $display("FAIL normal_done_width got %b want 0", done);
        end
    endtask

    task automatic test_refresh();
        logic [3:0] prev;
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        int found;
        int bad;
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        found = 0;
        bad = 0;
        prev = an;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (an === 4'b1110 && prev !== 4'b1110) found = 1;
            else prev = an;
        end
        n_checks++;
        if (found == 0) begin
            n_errors++; $display("FAIL refresh_sync got no 1110 phase start want one within 40 cycles");
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (i > 0) @(negedge clk);
                if (an !== an_exp[i/4] || seg !== seg_exp[i/4]) begin
                    bad++;
                    $display("FAIL refresh_step%0d got an %b seg %b want an %b seg %b",
                             i, an, seg, an_exp[i/4], seg_exp[i/4]);
                end
            end
            n_checks++;
            if (bad != 0) begin
                n_errors++; $display("FAIL refresh_seq got %0d bad cycles want 0", bad);
            end
        end
    endtask

    task automatic test_overflow();
        int bad;
        bad = 0;
        @(negedge clk);
        value = 32'd10000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_errors++; $display("FAIL ovf_busy got busy %b done %b want 1 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || ovf !== 1'b1 || {tho, hun, ten, one} !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL ovf_done got done %b ovf %b digits %h want 1 1 ffff", done, ovf, {tho, hun, ten, one});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (seg !== 7'b0111111) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL ovf_seg got %0d non-dash cycles want 0", bad);
        end
    endtask

    task automatic test_load_while_busy();
        int n_done;
        int done_at;
        n_done = 0;
        done_at = -1;
        @(negedge clk);
        value = 32'd9999; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 2) begin value = 32'd5; load = 1'b1; end
            if (i == 3) load = 1'b0;
            if (done === 1'b1) begin n_done++; done_at = i; end
        end
        n_checks++;
        if (n_done != 1 || done_at != 15) begin
            n_errors++; $display("FAIL busy_load_done got %0d pulses at %0d want 1 at 15", n_done, done_at);
        end
        n_checks++;
        if ({tho, hun, ten, one} !== 16'h9999 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL busy_load_digits got %h ovf %b want 9999 0", {tho, hun, ten, one}, ovf);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        n_done = 0;
        @(negedge clk);
        value = 32'd4321; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({tho, hun, ten, one} !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset got digits %h busy %b done %b want 0000 0 0", {tho, hun, ten, one}, busy, done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0 || {tho, hun, ten, one} !== 16'h0000) begin
            n_errors++;
            $display("FAIL mid_no_done got %0d active cycles digits %h want 0 0000", n_done, {tho, hun, ten, one});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; value = 32'd42; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++; $display("FAIL first_load got busy %b want 1", busy);
        end
        repeat (15) @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || {tho, hun, ten, one} !== 16'h0042 || ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset_42 got done %b digits %h ovf %b want 1 0042 0", done, {tho, hun, ten, one}, ovf);
        end
    endtask

    initial begin
        reset = 1'b0;
        load  = 1'b0;
        value = 32'd0;
        test_reset();
        test_normal();
        test_refresh();
        test_overflow();
        test_load_while_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit stays enabled; legal range 2..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1 bit: request to convert and display value; sampled only in IDLE.
REQ-005 The block SHALL have port value, input, 32 bits: unsigned binary value to display, e.g. register-file read data.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress (SHIFT or DONE state).
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the digit registers have just updated.
REQ-008 The block SHALL have port ovf, output, 1 bit: high when the last accepted value exceeded 9999.
REQ-009 The block SHALL have ports tho, hun, ten and one, each output, 4 bits: latched BCD digits (thousands, hundreds, tens, ones).
REQ-010 The block SHALL have port seg, output, 7 bits: active-low segments ordered {g,f,e,d,c,b,a}.
REQ-011 The block SHALL have port an, output, 4 bits: active-low one-hot digit enable; an[0]=ones through an[3]=thousands.

Function
REQ-012 The block SHALL implement an FSM with exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with load=1 and value<=9999, the block SHALL, on that edge, capture value[13:0] into a 14-bit shift register, clear a 16-bit BCD accumulator, clear the iteration counter and go to SHIFT.
REQ-014 In IDLE with load=1 and value>9999, the block SHALL go directly to DONE with an overflow flag set internally.
REQ-015 In SHIFT, each cycle SHALL perform one double-dabble step: every BCD nibble >=5 has 3 added, then {BCD, shift register} shifts left by 1.
REQ-016 After exactly 14 SHIFT steps, the block SHALL enter DONE.
REQ-017 On the edge leaving DONE, the block SHALL update tho/hun/ten/one from the accumulator, set ovf=0, assert done for one cycle and return to IDLE.
REQ-018 On the overflow path, the DONE-exit edge SHALL instead set all four digits to 4'hF and set ovf=1.
REQ-019 Latency SHALL be: load accepted at edge k gives digit update and done at edge k+15 (normal path) or edge k+1 (overflow path).
REQ-020 load while busy=1 SHALL be ignored, with no queuing; the in-flight conversion SHALL be unaffected by changes on value.
REQ-021 The displayed digits SHALL hold their last value until the next done.
REQ-022 A 16-bit refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0, running freely and independent of the FSM.
REQ-023 On each refresh-counter wrap, a 2-bit digit select SHALL advance 0->1->2->3->0.
REQ-024 an SHALL be the active-low one-hot decode of the digit select: select 0 gives an=1110, select 3 gives an=0111.
REQ-025 seg SHALL decode the selected digit: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, F (dash)=0111111, any other code = blank 1111111.
REQ-026 seg and an SHALL be registered outputs that switch on the same edge, so no ghosting cycle occurs.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, force state=IDLE, all digits 0, ovf=0, done=0, busy=0, refresh counter 0, digit select 0, an=1110 and seg=1000000.
REQ-028 Reset asserted mid-conversion SHALL abandon the conversion, and no done pulse SHALL follow.
REQ-029 After reset deasserts, the first load SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-030 Test 1, reset: apply reset -> an=1110, seg=1000000, tho/hun/ten/one=0, busy=0.
REQ-031 Test 2, normal conversion: value=1234, load pulse at edge k -> busy=1 for cycles k..k+14, done=1 for exactly one cycle after edge k+15, then tho=1, hun=2, ten=3, one=4, ovf=0.
REQ-032 Test 3, overflow: value=10000, load pulse -> done after edge k+1, ovf=1, all digits F, seg=0111111 for every an phase.
REQ-033 Test 4, load while busy: load 9999, then load 5 at k+3 -> ignored; result is 9,9,9,9 with a single done pulse.
REQ-034 Test 5, refresh: REFRESH_DIV=4 -> an cycles 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles; seg always matches the enabled digit.
REQ-035 Test 6, reset mid-conversion: reset asserted at k+7 of a conversion of 4321 -> digits remain 0, no done pulse; a new load of 42 afterwards gives 0,0,4,2.
